digit_scan_ctrl: RTL and testbench



---
 rtl/digit_scan_pkg.sv | 23 ++
 rtl/seg7_hex_decoder.sv | 15 +
 rtl/digit_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared constants for the 7-segment scan controller: register map, CTRL
// bit positions, blanking codes and the active-low hex font.
package digit_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SEL_OFF   = 4'b1111;

    localparam logic ADDR_VALUE = 1'b0;
    localparam logic ADDR_CTRL  = 1'b1;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIG_LSB = 1;
    localparam int CTRL_DIG_MSB = 4;
    localparam int CTRL_DP      = 5;
    localparam int CTRL_W       = 6;

    // Index 0 is the rightmost entry; segments {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [15:0][7:0] SEG_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern with decimal point.
module seg7_hex_decoder
    import digit_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_on_i,
    output logic [7:0] seg_o
);

    logic [7:0] glyph;

    assign glyph = SEG_FONT[nibble_i];
    assign seg_o = {~dp_on_i, glyph[6:0]};

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for three 4-digit 7-segment tube groups.
// Define DIGIT_SCAN_LZ_BLANK_EN to blank leading zeros per 16-bit half.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [7:0]  digital_tube1,
    output logic [7:0]  digital_tube2,
    output logic [3:0]  digital_Sel0,
    output logic [3:0]  digital_Sel1,
    output logic [3:0]  digital_Sel2
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [31:0]       value_q,   value_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [31:0]       shadow_q,  shadow_d;
    logic [15:0]       div_cnt_q, div_cnt_d;
    logic [1:0]        idx_q,     idx_d;
    logic [7:0]        tube0_q,   tube0_d;
    logic [7:0]        tube1_q,   tube1_d;
    logic [7:0]        tube2_q,   tube2_d;
    logic [3:0]        sel01_q,   sel01_d;
    logic [3:0]        sel2_q,    sel2_d;

    logic       en_rise;
    logic       wrap;
    logic       frame_end;
    logic       blank0;
    logic       blank1;
    logic [3:0] nib0;
    logic [3:0] nib1;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;

    assign rdata = (addr == ADDR_CTRL) ? {{(32-CTRL_W){1'b0}}, ctrl_q} : value_q;

    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        if (we && addr == ADDR_VALUE) value_d = wdata;
        if (we && addr == ADDR_CTRL)  ctrl_d  = wdata[CTRL_W-1:0];

        en_rise   = ~ctrl_q[CTRL_EN] & ctrl_d[CTRL_EN];
        wrap      = ctrl_q[CTRL_EN] && (div_cnt_q == DIV_LAST);
        frame_end = wrap && (idx_q == 2'd3);

        div_cnt_d = 16'd0;
        idx_d     = 2'd0;
        if (ctrl_d[CTRL_EN] && ctrl_q[CTRL_EN]) begin
            if (wrap) begin
                idx_d = idx_q + 2'd1;
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
                idx_d     = idx_q;
            end
        end

        // value_q is the pre-write value, so a same-cycle VALUE write waits a frame.
        shadow_d = (frame_end || en_rise) ? value_q : shadow_q;
    end

    // Outputs are computed from next state so they register together with idx.
    assign nib0 = shadow_d[{idx_d, 2'b00} +: 4];
    assign nib1 = shadow_d[5'd16 + {3'b000, idx_d, 2'b00} +: 4];

`ifdef DIGIT_SCAN_LZ_BLANK_EN
    logic [15:0] half0;
    logic [15:0] half1;
    assign half0  = shadow_d[15:0];
    assign half1  = shadow_d[31:16];
    assign blank0 = (idx_d != 2'd0) && ((half0 >> {idx_d, 2'b00}) == 16'h0000);
    assign blank1 = (idx_d != 2'd0) && ((half1 >> {idx_d, 2'b00}) == 16'h0000);
`else
    assign blank0 = 1'b0;
    assign blank1 = 1'b0;
`endif

    seg7_hex_decoder u_dec0 (
        .nibble_i (nib0),
        .dp_on_i  (1'b0),
        .seg_o    (seg0)
    );

    seg7_hex_decoder u_dec1 (
        .nibble_i (nib1),
        .dp_on_i  (1'b0),
        .seg_o    (seg1)
    );

    seg7_hex_decoder u_dec2 (
        .nibble_i (ctrl_d[CTRL_DIG_MSB:CTRL_DIG_LSB]),
        .dp_on_i  (ctrl_d[CTRL_DP]),
        .seg_o    (seg2)
    );

    always_comb begin
        tube0_d = SEG_BLANK;
        tube1_d = SEG_BLANK;
        tube2_d = SEG_BLANK;
        sel01_d = SEL_OFF;
        sel2_d  = SEL_OFF;
        if (ctrl_d[CTRL_EN]) begin
            tube0_d = blank0 ? SEG_BLANK : seg0;
            tube1_d = blank1 ? SEG_BLANK : seg1;
            sel01_d = ~(4'b0001 << idx_d);
            if (idx_d == 2'd0) begin
                tube2_d = seg2;
                sel2_d  = 4'b1110;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q   <= '0;
            ctrl_q    <= '0;
            shadow_q  <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            tube0_q   <= SEG_BLANK;
            tube1_q   <= SEG_BLANK;
            tube2_q   <= SEG_BLANK;
            sel01_q   <= SEL_OFF;
            sel2_q    <= SEL_OFF;
        end else begin
            value_q   <= value_d;
            ctrl_q    <= ctrl_d;
            shadow_q  <= shadow_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            tube0_q   <= tube0_d;
            tube1_q   <= tube1_d;
            tube2_q   <= tube2_d;
            sel01_q   <= sel01_d;
            sel2_q    <= sel2_d;
        end
    end

    assign digital_tube0 = tube0_q;
    assign digital_tube1 = tube1_q;
    assign digital_tube2 = tube2_q;
    assign digital_Sel0  = sel01_q;
    assign digital_Sel1  = sel01_q;
    assign digital_Sel2  = sel2_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl with SCAN_DIV=4.
module tb_digit_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        we;
    logic        addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_Sel0, digital_Sel1, digital_Sel2;

    int checks;
    int failures;
    int kpos;

    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    digit_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .digital_tube0 (digital_tube0),
        .digital_tube1 (digital_tube1),
        .digital_tube2 (digital_tube2),
        .digital_Sel0  (digital_Sel0),
        .digital_Sel1  (digital_Sel1),
        .digital_Sel2  (digital_Sel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input logic [15:0] h, input int i);
        logic [3:0] n;
        bit         lead;
        n    = h[4*i +: 4];
        lead = 1'b0;
`ifdef DIGIT_SCAN_LZ_BLANK_EN
        if (i != 0) begin
            lead = 1'b1;
            for (int j = i; j < 4; j++)
                if (h[4*j +: 4] != 4'h0) lead = 1'b0;
        end
`endif
        return lead ? 8'hFF : FONT[n];
    endfunction

    // {tube0, tube1, tube2, sel0, sel1, sel2}
    function automatic logic [35:0] exp_outs(input logic [31:0] v, input logic [5:0] c, input int idx);
        logic [7:0] t0, t1, t2;
        logic [3:0] s01, s2;
        if (!c[0]) return {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF};
        t0 = exp_seg(v[15:0], idx);
        t1 = exp_seg(v[31:16], idx);
        case (idx)
            0:       s01 = 4'b1110;
            1:       s01 = 4'b1101;
            2:       s01 = 4'b1011;
            default: s01 = 4'b0111;
        endcase
        t2 = (idx == 0) ? {~c[5], FONT[c[4:1]][6:0]} : 8'hFF;
        s2 = (idx == 0) ? 4'b1110 : 4'b1111;
        return {t0, t1, t2, s01, s01, s2};
    endfunction

    function automatic logic [35:0] dut_outs();
        return {digital_tube0, digital_tube1, digital_tube2, digital_Sel0, digital_Sel1, digital_Sel2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        kpos++;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        kpos++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_outs() !== {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=%h", dut_outs(), {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF});
        end
        addr = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_value got=%h exp=%h", rdata, 32'h0);
        end
        addr = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_ctrl got=%h exp=%h", rdata, 32'h0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_enable_scan();
        wr(1'b0, 32'h1234ABCD);
        addr = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL rd_value got=%h exp=%h", rdata, 32'h1234ABCD);
        end
        checks++;
        if (dut_outs() !== {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL still_disabled got=%h exp=%h", dut_outs(), {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF});
        end
        wr(1'b1, 32'h1);
        kpos = 0;
        checks++;
        if ({digital_Sel0, digital_tube0, digital_tube1} !== {4'b1110, 8'hA1, 8'h99}) begin
            failures++;
            $display("FAIL enable_first_digit got=%h exp=%h",
                     {digital_Sel0, digital_tube0, digital_tube1}, {4'b1110, 8'hA1, 8'h99});
        end
        while (kpos < 16) begin
            checks++;
            if (dut_outs() !== exp_outs(32'h1234ABCD, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL scan k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'h1234ABCD, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
    endtask

    task automatic test_midframe_write();
        while (kpos < 20) step();
        wr(1'b0, 32'hFFFFFFFF);
        while (kpos < 32) begin
            checks++;
            if (dut_outs() !== exp_outs(32'h1234ABCD, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL midframe_old k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'h1234ABCD, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
        while (kpos < 48) begin
            checks++;
            if (dut_outs() !== exp_outs(32'hFFFFFFFF, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL midframe_new k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'hFFFFFFFF, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
    endtask

    task automatic test_frame_end_write();
        while (kpos < 63) step();
        wr(1'b0, 32'h76543210);
        while (kpos < 80) begin
            checks++;
            if (dut_outs() !== exp_outs(32'hFFFFFFFF, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL frame_end_old k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'hFFFFFFFF, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
        while (kpos < 96) begin
            checks++;
            if (dut_outs() !== exp_outs(32'h76543210, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL frame_end_new k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'h76543210, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
    endtask

    task automatic test_tube2_disable();
        wr(1'b1, 32'hFFFFFFEB);
        addr = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0000002B) begin
            failures++;
            $display("FAIL rd_ctrl got=%h exp=%h", rdata, 32'h0000002B);
        end
        checks++;
        if ({digital_tube2, digital_Sel2} !== {8'h12, 4'b1110}) begin
            failures++;
            $display("FAIL tube2_idx0 got=%h exp=%h", {digital_tube2, digital_Sel2}, {8'h12, 4'b1110});
        end
        while (kpos < 112) begin
            checks++;
            if (dut_outs() !== exp_outs(32'h76543210, 6'h2B, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL tube2_scan k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'h76543210, 6'h2B, (kpos / 4) % 4));
            end
            step();
        end
        wr(1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut_outs() !== {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF}) begin
                failures++;
                $display("FAIL disable_blank i=%0d got=%h exp=%h", i, dut_outs(), {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF});
            end
            step();
        end
    endtask

    task automatic test_leading_zero();
        wr(1'b0, 32'h00000007);
        wr(1'b1, 32'h1);
        kpos = 0;
        while (kpos < 16) begin
            checks++;
            if (dut_outs() !== exp_outs(32'h00000007, 6'h01, (kpos / 4) % 4)) begin
                failures++;
                $display("FAIL lz k=%0d got=%h exp=%h", kpos, dut_outs(), exp_outs(32'h00000007, 6'h01, (kpos / 4) % 4));
            end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        while (kpos < 21) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_outs() !== {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL async_reset_outs got=%h exp=%h", dut_outs(), {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF});
        end
        addr = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_value got=%h exp=%h", rdata, 32'h0);
        end
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (dut_outs() !== {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", dut_outs(), {8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        kpos     = 0;
        test_reset();
        test_enable_scan();
        test_midframe_write();
        test_frame_end_write();
        test_tube2_disable();
        test_leading_zero();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
